// File: rtl/mask_streamer_pkg.sv
// Shared types and constants for the mask streamer.
// Optional build macro: MASK_STREAMER_READY_EN (adds out_ready).
package mask_streamer_pkg;

  localparam int WORD_BITS = 32;
  localparam int IDX_W     = 5;
  localparam int GAP_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    FINISH
  } state_t;

endpackage

// File: rtl/mask_word_shifter.sv
// Current word plus one-word prefetch buffer.
// Hands out one mask bit per shift, LSB first.
module mask_word_shifter
  import mask_streamer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 shift,
  output logic                 pixel,
  output logic                 avail,
  output logic                 first
);

  logic [WORD_BITS-1:0] cur;
  logic [WORD_BITS-1:0] pf;
  logic                 cur_v;
  logic                 pf_v;
  logic [IDX_W-1:0]     idx;
  logic                 last_bit;

  assign last_bit = (idx == '1);
  assign pixel    = cur[idx];
  assign avail    = cur_v;
  assign first    = (idx == '0);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      cur   <= '0;
      pf    <= '0;
      cur_v <= 1'b0;
      pf_v  <= 1'b0;
      idx   <= '0;
    end else begin
      if (shift) begin
        idx <= idx + 1'b1;
        if (last_bit) begin
          cur   <= pf;
          cur_v <= pf_v;
          pf_v  <= 1'b0;
        end
      end
      // Arriving word fills the current slot if it is (about to be) empty
      if (load) begin
        if (!cur_v || (shift && last_bit && !pf_v)) begin
          cur   <= data;
          cur_v <= 1'b1;
        end else begin
          pf    <= data;
          pf_v  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mask_streamer.sv
// Streams a packed binary mask from memory as paced pixel strobes.
// Optional build macro: MASK_STREAMER_READY_EN (adds out_ready).
module mask_streamer
  import mask_streamer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int GAP    = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              out_write,
  output logic              out_pixel,
  output logic              out_busy,
  output logic              out_done
`ifdef MASK_STREAMER_READY_EN
  ,
  input  logic              out_ready
`endif
);

  state_t           state;
  logic [31:0]      total;
  logic [31:0]      cnt;
  logic [31:0]      word_cnt;
  logic [26:0]      n_words;
  logic             outstanding;
  logic             req_pend;
  logic             wr_q;
  logic             pix_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             rdy;
  logic             fire;
  logic             load;
  logic             emit;
  logic             sh_pixel;
  logic             sh_avail;
  logic             sh_first;
  logic             accept;

`ifdef MASK_STREAMER_READY_EN
  assign rdy = out_ready;
`else
  assign rdy = 1'b1;
`endif

  assign fire      = wr_q & rdy;
  assign out_write = fire;
  assign out_pixel = pix_q;
  assign load      = mem_valid & outstanding;
  assign accept    = (state == IDLE) & start;
  assign n_words   = total[31:5]
                   + {26'b0, |total[4:0]};
  assign emit      = (state == STREAM)
                   && (cnt != total)
                   && sh_avail
                   && (gap_cnt == '0)
                   && !wr_q;

  mask_word_shifter u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .load    (load),
    .data    (mem_rdata),
    .shift   (emit),
    .pixel   (sh_pixel),
    .avail   (sh_avail),
    .first   (sh_first)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      total       <= '0;
      cnt         <= '0;
      word_cnt    <= '0;
      outstanding <= 1'b0;
      req_pend    <= 1'b0;
      wr_q        <= 1'b0;
      pix_q       <= 1'b0;
      gap_cnt     <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      out_busy    <= 1'b0;
      out_done    <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      if (load)
        outstanding <= 1'b0;
      // Low time after a strobe counts from the handshake cycle
      if (fire) begin
        wr_q    <= 1'b0;
        gap_cnt <= GAP_W'(GAP - 1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      unique case (state)
        IDLE: begin
          out_done <= 1'b0;
          if (start) begin
            total    <= 32'(width) * 32'(height);
            cnt      <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
            req_pend <= 1'b0;
            if (width == '0 || height == '0) begin
              state    <= FINISH;
              out_done <= 1'b1;
            end else begin
              state    <= FETCH;
              out_busy <= 1'b1;
            end
          end
        end
        FETCH: begin
          mem_rd      <= 1'b1;
          mem_addr    <= '0;
          word_cnt    <= 32'd1;
          outstanding <= 1'b1;
          state       <= STREAM;
        end
        STREAM: begin
          if (emit) begin
            wr_q  <= 1'b1;
            pix_q <= sh_pixel;
            cnt   <= cnt + 1'b1;
            if (sh_first && word_cnt < {5'b0, n_words})
              req_pend <= 1'b1;
          end
          if (req_pend) begin
            mem_rd      <= 1'b1;
            mem_addr    <= ADDR_W'(word_cnt);
            word_cnt    <= word_cnt + 1'b1;
            outstanding <= 1'b1;
            req_pend    <= 1'b0;
          end
          if (cnt == total && (fire || !wr_q)) begin
            state    <= FINISH;
            out_done <= 1'b1;
            out_busy <= 1'b0;
          end
        end
        FINISH: begin
          out_done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
